// File: rtl/dsram_arbiter_if.sv
// Data SRAM arbiter bus bundle.
// Carries the CPU load/store port, the aux (debug/DMA) burst port, the
// pipeline stall request and the SRAM control/data lines.
// slave  : arbiter side (takes requests, drives grants and SRAM controls).
// master : environment side (drives requests and SRAM read data).
interface dsram_arbiter_if;
    logic        cpu_req;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        aux_req;
    logic [3:0]  aux_wen;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_last;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;

    logic        stallreq_mem;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  aux_req, aux_wen, aux_addr, aux_wdata, aux_last,
        output aux_gnt, aux_rvalid, aux_rdata,
        output stallreq_mem,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output aux_req, aux_wen, aux_addr, aux_wdata, aux_last,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  stallreq_mem,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/dsram_arbiter.sv
// Single-ported data SRAM arbiter/sequencer.
// Shares the SRAM between the CPU load/store port and an aux burst master.
// Grants and SRAM controls are combinational (access issued in the grant
// cycle); reads return one cycle later and are routed by an owner register.
// Ports: clk, resetn (async active-low), bus (dsram_arbiter_if.slave).
// Params: STARVE_MAX - max denied cycles for aux before it is forced in;
//         BURST_MAX  - max cycles the CPU may be blocked by an aux burst.
module dsram_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic            clk,
    input  logic            resetn,
    dsram_arbiter_if.slave  bus
);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_AUX = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

    logic       state, state_nxt;
    logic [3:0] aux_wait, cpu_wait;
    logic       cpu_sel, aux_sel;
    logic       rd_vld, rd_aux;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= OWN_CPU;
        else         state <= state_nxt;
    end

    // Next-state logic: an aux beat opens or closes the burst
    always_comb begin
        state_nxt = state;
        case (state)
            OWN_CPU: if (bus.aux_gnt && !bus.aux_last) state_nxt = OWN_AUX;
            OWN_AUX: if (bus.aux_gnt &&  bus.aux_last) state_nxt = OWN_CPU;
            default: state_nxt = OWN_CPU;
        endcase
    end

    // Output logic: grant selection and SRAM mux
    always_comb begin
        cpu_sel = 1'b0;
        aux_sel = 1'b0;
        case (state)
            OWN_CPU: begin
                if (bus.aux_req && aux_wait == STARVE_LIM) aux_sel = 1'b1;
                else if (bus.cpu_req)                      cpu_sel = 1'b1;
                else if (bus.aux_req)                      aux_sel = 1'b1;
            end
            default: begin
                // Forced CPU beat first, then burst beats; CPU fills burst gaps
                if (bus.cpu_req && cpu_wait == BURST_LIM) cpu_sel = 1'b1;
                else if (bus.aux_req)                     aux_sel = 1'b1;
                else if (bus.cpu_req)                     cpu_sel = 1'b1;
            end
        endcase
    end

    // Nothing reaches the SRAM while reset is held
    assign bus.cpu_gnt      = cpu_sel & resetn;
    assign bus.aux_gnt      = aux_sel & resetn;
    assign bus.stallreq_mem = bus.cpu_req & ~bus.cpu_gnt;
    assign bus.data_sram_en = bus.cpu_gnt | bus.aux_gnt;

    always_comb begin
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        if (bus.cpu_gnt) begin
            bus.data_sram_wen   = bus.cpu_wen;
            bus.data_sram_addr  = bus.cpu_addr;
            bus.data_sram_wdata = bus.cpu_wdata;
        end else if (bus.aux_gnt) begin
            bus.data_sram_wen   = bus.aux_wen;
            bus.data_sram_addr  = bus.aux_addr;
            bus.data_sram_wdata = bus.aux_wdata;
        end
    end

    // Starvation counters, saturating at their limits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aux_wait <= 4'h0;
            cpu_wait <= 4'h0;
        end else begin
            if (bus.aux_gnt)                             aux_wait <= 4'h0;
            else if (bus.aux_req && aux_wait != STARVE_LIM) aux_wait <= aux_wait + 4'h1;
            if (bus.cpu_gnt)                             cpu_wait <= 4'h0;
            else if (bus.cpu_req && cpu_wait != BURST_LIM)  cpu_wait <= cpu_wait + 4'h1;
        end
    end

    // Read owner: tags the one-cycle-later return with its requester
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld <= 1'b0;
            rd_aux <= 1'b0;
        end else begin
            rd_vld <= (bus.cpu_gnt && bus.cpu_wen == 4'h0) ||
                      (bus.aux_gnt && bus.aux_wen == 4'h0);
            rd_aux <= bus.aux_gnt;
        end
    end

    assign bus.cpu_rvalid = rd_vld & ~rd_aux;
    assign bus.aux_rvalid = rd_vld &  rd_aux;
    assign bus.cpu_rdata  = bus.data_sram_rdata;
    assign bus.aux_rdata  = bus.data_sram_rdata;
endmodule
